ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised successor to the combinational control decoder: owns the LOAD/FETCH/DECODE/EXECUTE stage machine instead of taking `stage` as an input. It also generalises instruction width, counts the program-load phase to a configurable depth, and adds run/hold and data-memory ready handshakes. It sits between program memory, the IR, the datapath (PC, Acc, SR, DR, ALU, MUX1/MUX2) and data memory, and drives every enable in the core.

## Interface
- `IW`, 12: instruction width; must be ≥12. Decode fields are anchored at the MSB.
- `PROG_DEPTH`, 256: number of program words accepted in LOAD.
- `AW`, 8: load address width; must satisfy 2^AW ≥ PROG_DEPTH.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `run` in 1: when 1, FETCH may advance; when 0, hold in FETCH.
- `load_valid` in 1: one program word is present on the load bus this cycle.
- `dmem_ready` in 1: data memory completes its access this cycle (used only with the stall feature).
- `IR` in IW: current instruction.
- `SR` in 4: status flags {Z, C, S, O}, indexed for jumps.
- `stage` out 2: LOAD=0, FETCH=1, DECODE=2, EXECUTE=3.
- `load_addr` out AW: PMem write address during LOAD.
- `load_done` out 1: high once all PROG_DEPTH words are loaded; stays high until reset.
- `ALU_Mode` out 4: ALU operation select.
- `PC_E, Acc_E, SR_E, IR_E, DR_E, PMem_E, PMem_LE, DMem_E, DMem_WE, ALU_E, MUX1_Sel, MUX2_Sel` out 1 each: datapath enables and selects.

## Operation
Decode classes, evaluated in priority order:
- **Immediate ALU**: `IR[IW-1]=1`.
- **Jump**: `IR[IW-2]=1`.
- **Memory ALU**: `IR[IW-3]=1`.
- **GOTO**: `IR[IW-4]=1`.
- **NOP**: none of the above.

Per stage:
- **Stage register**: reset value LOAD.
- **Load address counter**: reset value 0.
- **LOAD**
  - `PMem_E=PMem_LE=load_valid`.
  - Each accepted word increments `load_addr`.
  - On the word at `load_addr==PROG_DEPTH-1`: set `load_done`, `load_addr` wraps to 0, next stage is FETCH.
- **FETCH**
  - `IR_E=PMem_E=1` only when `run=1`; next stage is DECODE.
  - `run=0`: all outputs 0, stay in FETCH.
- **DECODE**
  - Memory ALU class (`IR[IW-1:IW-3]=001`): `DR_E=DMem_E=1`.
  - Otherwise: all outputs 0.
  - Next stage is EXECUTE.
- **EXECUTE**: next stage is FETCH.
  - Immediate ALU: `PC_E=Acc_E=SR_E=ALU_E=MUX1_Sel=MUX2_Sel=1`, `ALU_Mode={1'b0,IR[IW-2:IW-4]}`.
  - Jump: `PC_E=1`, `MUX1_Sel=SR[IR[IW-3:IW-4]]`.
  - Memory ALU:
    - `PC_E=SR_E=ALU_E=1`, `ALU_Mode=IR[IW-5:IW-8]`.
    - `Acc_E=IR[IW-4]`.
    - `DMem_E=DMem_WE=~IR[IW-4]`.
  - GOTO: `PC_E=MUX1_Sel=1`.
  - NOP: `PC_E=1`, `MUX1_Sel=0`.
- **Unlisted outputs**: 0 in every stage.
- **Reset behaviour**
  - While `rst=0`, all enables are forced to 0 regardless of stage.
  - Reset mid-operation aborts any load or execution and returns to LOAD with `load_addr=0`, `load_done=0`.
  - A previously loaded program is retained in PMem but is re-loaded on the next load.

## Timing
- **Stage transitions**: one per cycle. Without stalls an instruction takes 3 cycles (FETCH, DECODE, EXECUTE).
- **Enable timing**
  - All enables and selects are combinational from `stage`, `IR`, `SR` and the handshake inputs; zero latency within the cycle.
  - PC/Acc/SR/DMem updates land at the rising edge ending the cycle in which their enable is high.
- **Load phase**
  - Takes exactly PROG_DEPTH accepted words; `load_valid` gaps simply hold the counter.
  - `load_valid` outside LOAD is ignored.
- **Jump condition**: `SR` is sampled in EXECUTE only.

## Configuration
- `CTRL_SEQ_STALL_EN` **defined**: `dmem_ready` gates memory-class steps.
  - **DECODE**: `DMem_E` is held while `dmem_ready=0`. `DR_E` is asserted only in the cycle `dmem_ready=1`, and the stage holds in DECODE until then.
  - **EXECUTE**: `DMem_E`/`DMem_WE` are held while `dmem_ready=0`. `PC_E`, `Acc_E`, `SR_E` and `ALU_E` are asserted only in the cycle `dmem_ready=1`, and the stage holds in EXECUTE until then.
  - Non-memory classes ignore `dmem_ready`.
- `CTRL_SEQ_STALL_EN` **undefined**: `dmem_ready` is unused; memory-class steps complete in one cycle, as listed under Operation.

## Test plan
- **Reset and load**: IW=12, PROG_DEPTH=4, rst low 2 cycles then high, `load_valid` pattern 1,0,1,1,1.
  - `load_addr` steps 0,1,1,2,3.
  - `load_done` rises after the 5th cycle; stage becomes FETCH.
  - `PMem_LE` mirrors `load_valid`.
- **Immediate ALU**: IR=12'hA37, run=1.
  - FETCH: `IR_E=1`.
  - DECODE: all outputs 0.
  - EXECUTE: `ALU_Mode=4'h2`, `Acc_E=SR_E=ALU_E=MUX1_Sel=MUX2_Sel=PC_E=1`.
- **Jump**: IR=12'h700 (IR[9:8]=3), SR=4'b1000, so `MUX1_Sel=1` in EXECUTE. Repeat with SR=4'b0000, so `MUX1_Sel=0`.
- **Memory ALU with store**: IR=12'h250.
  - DECODE: `DR_E=DMem_E=1`.
  - EXECUTE: `DMem_WE=DMem_E=1`, `Acc_E=0`, `ALU_Mode=4'h5`.
  - With `CTRL_SEQ_STALL_EN` and `dmem_ready` low for 3 cycles: EXECUTE lasts 4 cycles and `PC_E` pulses once, in the last cycle.
- **Hold and reset**
  - `run=0` in FETCH for 5 cycles: stage stays 1, all enables 0.
  - `rst=0` asserted during EXECUTE: next stage LOAD, `load_addr=0`, `load_done=0`.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Control sequencer: owns the LOAD/FETCH/DECODE/EXECUTE stage machine and drives every datapath enable.
// Optional macro CTRL_SEQ_STALL_EN lets dmem_ready stall memory-class DECODE/EXECUTE steps.
module ctrl_sequencer #(
  parameter int IW         = 12,
  parameter int PROG_DEPTH = 256,
  parameter int AW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          load_valid,
  input  logic          dmem_ready,
  input  logic [IW-1:0] IR,
  input  logic [3:0]    SR,
  output logic [1:0]    stage,
  output logic [AW-1:0] load_addr,
  output logic          load_done,
  output logic [3:0]    ALU_Mode,
  output logic          PC_E,
  output logic          Acc_E,
  output logic          SR_E,
  output logic          IR_E,
  output logic          DR_E,
  output logic          PMem_E,
  output logic          PMem_LE,
  output logic          DMem_E,
  output logic          DMem_WE,
  output logic          ALU_E,
  output logic          MUX1_Sel,
  output logic          MUX2_Sel
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FETCH   = 2'd1,
    DECODE  = 2'd2,
    EXECUTE = 2'd3
  } stage_t;

  stage_t        r_stage;
  stage_t        w_nextStage;
  logic [AW-1:0] r_loadAddr;
  logic          r_loadDone;

  logic w_isImm;
  logic w_isJump;
  logic w_isMem;
  logic w_isGoto;
  logic w_lastWord;
  logic w_memReady;
  logic w_unused;

  // Classes are mutually exclusive here so the priority order is baked into the decode.
  assign w_isImm    = IR[IW-1];
  assign w_isJump   = ~IR[IW-1] & IR[IW-2];
  assign w_isMem    = (IR[IW-1:IW-3] == 3'b001);
  assign w_isGoto   = (IR[IW-1:IW-4] == 4'b0001);
  assign w_lastWord = (r_loadAddr == AW'(PROG_DEPTH - 1));

`ifdef CTRL_SEQ_STALL_EN
  assign w_memReady = dmem_ready;
`else
  assign w_memReady = 1'b1;
`endif

  assign w_unused = ^{dmem_ready, IR[IW-9:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stage    <= LOAD;
      r_loadAddr <= '0;
      r_loadDone <= 1'b0;
    end else begin
      r_stage <= w_nextStage;
      if (r_stage == LOAD && load_valid) begin
        if (w_lastWord) begin
          r_loadAddr <= '0;
          r_loadDone <= 1'b1;
        end else begin
          r_loadAddr <= r_loadAddr + AW'(1);
        end
      end
    end
  end

  always_comb begin
    w_nextStage = r_stage;
    case (r_stage)
      LOAD:    if (load_valid && w_lastWord) w_nextStage = FETCH;
      FETCH:   if (run) w_nextStage = DECODE;
      DECODE:  if (!w_isMem || w_memReady) w_nextStage = EXECUTE;
      EXECUTE: if (!w_isMem || w_memReady) w_nextStage = FETCH;
      default: w_nextStage = LOAD;
    endcase
  end

  // Enables stay at zero for the whole time reset is held low.
  always_comb begin
    ALU_Mode = 4'h0;
    PC_E     = 1'b0;
    Acc_E    = 1'b0;
    SR_E     = 1'b0;
    IR_E     = 1'b0;
    DR_E     = 1'b0;
    PMem_E   = 1'b0;
    PMem_LE  = 1'b0;
    DMem_E   = 1'b0;
    DMem_WE  = 1'b0;
    ALU_E    = 1'b0;
    MUX1_Sel = 1'b0;
    MUX2_Sel = 1'b0;
    if (rst) begin
      case (r_stage)
        LOAD: begin
          PMem_E  = load_valid;
          PMem_LE = load_valid;
        end
        FETCH: begin
          IR_E   = run;
          PMem_E = run;
        end
        DECODE: begin
          if (w_isMem) begin
            DMem_E = 1'b1;
            DR_E   = w_memReady;
          end
        end
        EXECUTE: begin
          if (w_isImm) begin
            PC_E     = 1'b1;
            Acc_E    = 1'b1;
            SR_E     = 1'b1;
            ALU_E    = 1'b1;
            MUX1_Sel = 1'b1;
            MUX2_Sel = 1'b1;
            ALU_Mode = {1'b0, IR[IW-2:IW-4]};
          end else if (w_isJump) begin
            PC_E     = 1'b1;
            MUX1_Sel = SR[IR[IW-3:IW-4]];
          end else if (w_isMem) begin
            PC_E     = w_memReady;
            SR_E     = w_memReady;
            ALU_E    = w_memReady;
            Acc_E    = IR[IW-4] & w_memReady;
            DMem_E   = ~IR[IW-4];
            DMem_WE  = ~IR[IW-4];
            ALU_Mode = IR[IW-5:IW-8];
          end else if (w_isGoto) begin
            PC_E     = 1'b1;
            MUX1_Sel = 1'b1;
          end else begin
            PC_E = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stage     = r_stage;
  assign load_addr = r_loadAddr;
  assign load_done = r_loadDone;

endmodule
